// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_arbiter
// Purpose  : Write-side producer for the general-purpose register file.
//            Accepts EXU and LSU results over valid/ready handshakes and
//            buffers each source in its own FIFO. It then arbitrates one pop
//            per cycle onto the registered register-file write port. Writes
//            to x0 are dropped at acceptance. A starvation counter forces an
//            EXU pop after STARVE_LIMIT consecutive lost arbitrations.
// Ports    : clk                    - clock, rising edge
//            rst                    - synchronous reset, active low
//            exu_valid/ready/rd/data - EXU result handshake
//            lsu_valid/ready/rd/data - LSU load result handshake
//            wen/waddr/wdata        - registered register-file write port
//            idle                   - no buffered entries and no write issuing
// Revision : 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter #(
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exu_valid,
   output logic                  exu_ready,
   input  logic [ADDR_WIDTH-1:0] exu_rd,
   input  logic [DATA_WIDTH-1:0] exu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  idle
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   localparam logic [CNT_W-1:0] C_FULL   = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] C_CNT1   = CNT_W'(1);
   localparam logic [PTR_W-1:0] C_PTR1   = PTR_W'(1);
   localparam logic [SC_W-1:0]  C_STARVE = SC_W'(STARVE_LIMIT);
   localparam logic [SC_W-1:0]  C_SC1    = SC_W'(1);

   // ------------------------------------------------------------------------
   // FIFO storage and state
   // ------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] exu_rd_mem_q   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] exu_data_mem_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] lsu_rd_mem_q   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] lsu_data_mem_q [FIFO_DEPTH];

   logic [PTR_W-1:0] exu_wptr_q, exu_rptr_q, lsu_wptr_q, lsu_rptr_q;
   logic [CNT_W-1:0] exu_cnt_q, exu_cnt_d, lsu_cnt_q, lsu_cnt_d;
   logic [SC_W-1:0]  starve_q, starve_d;

   logic                  wen_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic exu_accept, lsu_accept;
   logic exu_push, lsu_push;
   logic exu_ne, lsu_ne;
   logic exu_pop, lsu_pop;

   // Ready depends only on the stored count (and reset), never on this
   // cycle's pop, so a full FIFO stays closed even while it drains.
   assign exu_ready = rst && (exu_cnt_q != C_FULL);
   assign lsu_ready = rst && (lsu_cnt_q != C_FULL);

   assign exu_accept = exu_valid && exu_ready;
   assign lsu_accept = lsu_valid && lsu_ready;

   // x0 results complete the handshake but are never stored.
   assign exu_push = exu_accept && (exu_rd != '0);
   assign lsu_push = lsu_accept && (lsu_rd != '0);

   assign exu_ne = (exu_cnt_q != '0);
   assign lsu_ne = (lsu_cnt_q != '0);

   // LSU wins by default; EXU wins when it is alone or has been starved.
   assign lsu_pop = lsu_ne && !(exu_ne && (starve_q == C_STARVE));
   assign exu_pop = exu_ne && !lsu_pop;

   // ------------------------------------------------------------------------
   // Next-state for counts and the starvation counter
   // ------------------------------------------------------------------------
   always_comb begin
      exu_cnt_d = exu_cnt_q;
      case ({exu_push, exu_pop})
         2'b10:   exu_cnt_d = exu_cnt_q + C_CNT1;
         2'b01:   exu_cnt_d = exu_cnt_q - C_CNT1;
         default: exu_cnt_d = exu_cnt_q;
      endcase

      lsu_cnt_d = lsu_cnt_q;
      case ({lsu_push, lsu_pop})
         2'b10:   lsu_cnt_d = lsu_cnt_q + C_CNT1;
         2'b01:   lsu_cnt_d = lsu_cnt_q - C_CNT1;
         default: lsu_cnt_d = lsu_cnt_q;
      endcase

      // Counts cycles where EXU waits while LSU takes the port; any other
      // case (EXU popped or EXU empty) clears it.
      starve_d = '0;
      if (exu_ne && lsu_pop) begin
         starve_d = (starve_q == C_STARVE) ? starve_q : (starve_q + C_SC1);
      end
   end

   // ------------------------------------------------------------------------
   // Storage writes (contents need no reset; pointers/counts qualify them)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (exu_push) begin
         exu_rd_mem_q[exu_wptr_q]   <= exu_rd;
         exu_data_mem_q[exu_wptr_q] <= exu_data;
      end
      if (lsu_push) begin
         lsu_rd_mem_q[lsu_wptr_q]   <= lsu_rd;
         lsu_data_mem_q[lsu_wptr_q] <= lsu_data;
      end
   end

   // ------------------------------------------------------------------------
   // Control state and registered write port
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         exu_wptr_q <= '0;
         exu_rptr_q <= '0;
         lsu_wptr_q <= '0;
         lsu_rptr_q <= '0;
         exu_cnt_q  <= '0;
         lsu_cnt_q  <= '0;
         starve_q   <= '0;
         wen_q      <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         exu_cnt_q <= exu_cnt_d;
         lsu_cnt_q <= lsu_cnt_d;
         starve_q  <= starve_d;

         // Power-of-two depth: pointers wrap naturally at their width.
         if (exu_push) exu_wptr_q <= exu_wptr_q + C_PTR1;
         if (lsu_push) lsu_wptr_q <= lsu_wptr_q + C_PTR1;
         if (exu_pop)  exu_rptr_q <= exu_rptr_q + C_PTR1;
         if (lsu_pop)  lsu_rptr_q <= lsu_rptr_q + C_PTR1;

         if (exu_pop) begin
            wen_q   <= 1'b1;
            waddr_q <= exu_rd_mem_q[exu_rptr_q];
            wdata_q <= exu_data_mem_q[exu_rptr_q];
         end else if (lsu_pop) begin
            wen_q   <= 1'b1;
            waddr_q <= lsu_rd_mem_q[lsu_rptr_q];
            wdata_q <= lsu_data_mem_q[lsu_rptr_q];
         end else begin
            wen_q   <= 1'b0;
         end
      end
   end

   assign wen   = wen_q;
   assign waddr = waddr_q;
   assign wdata = wdata_q;
   assign idle  = (exu_cnt_q == '0) && (lsu_cnt_q == '0) && !wen_q;

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_wb_arbiter
// Purpose  : Directed self-checking bench for gpr_wb_arbiter. It covers reset,
//            single writes, x0 filtering, LSU priority with the EXU
//            starvation guard, backpressure, and reset during traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        exu_valid = 1'b0;
   logic        exu_ready;
   logic [4:0]  exu_rd = '0;
   logic [31:0] exu_data = '0;
   logic        lsu_valid = 1'b0;
   logic        lsu_ready;
   logic [4:0]  lsu_rd = '0;
   logic [31:0] lsu_data = '0;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        idle;

   int n_pass  = 0;
   int n_total = 0;

   // Every write seen on the port, in issue order.
   logic [4:0]  wq_addr[$];
   logic [31:0] wq_data[$];

   gpr_wb_arbiter #(
      .ADDR_WIDTH  (5),
      .DATA_WIDTH  (32),
      .FIFO_DEPTH  (2),
      .STARVE_LIMIT(3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .exu_valid(exu_valid),
      .exu_ready(exu_ready),
      .exu_rd   (exu_rd),
      .exu_data (exu_data),
      .lsu_valid(lsu_valid),
      .lsu_ready(lsu_ready),
      .lsu_rd   (lsu_rd),
      .lsu_data (lsu_data),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .idle     (idle)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst && wen) begin
         wq_addr.push_back(waddr);
         wq_data.push_back(wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      int guard;
      int ei;
      int li;
      int cyc;
      int ne;
      int nl;
      logic acc;
      logic ea;
      logic la;
      logic er_exp [6];
      logic [4:0]  st_addr [9];
      logic [31:0] st_data [9];

      er_exp  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      st_addr = '{5'd2, 5'd3, 5'd4, 5'd1, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
      st_data = '{32'h202, 32'h203, 32'h204, 32'h100, 32'h205,
                  32'h206, 32'h207, 32'h208, 32'h209};

      // ---------------- Reset with valids asserted ----------------
      rst = 1'b0;
      exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h77;
      lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
      step();
      step();
      chk("rst_exu_ready", exu_ready, 0);
      chk("rst_lsu_ready", lsu_ready, 0);
      chk("rst_wen", wen, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_idle", idle, 1);
      rst = 1'b1;
      exu_valid = 1'b0;
      lsu_valid = 1'b0;
      #1;
      chk("rel_exu_ready", exu_ready, 1);
      chk("rel_lsu_ready", lsu_ready, 1);
      step();

      // ---------------- Single EXU write ----------------
      wq_addr.delete(); wq_data.delete();
      exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
      step();                                   // edge T: accepted
      exu_valid = 1'b0;
      chk("single_wen_T", wen, 0);
      chk("single_idle_T", idle, 0);
      step();                                   // edge T+1
      chk("single_wen_T1", wen, 1);
      chk("single_waddr_T1", waddr, 5);
      chk("single_wdata_T1", wdata, 32'hDEADBEEF);
      step();                                   // edge T+2
      chk("single_wen_T2", wen, 0);
      chk("single_waddr_hold", waddr, 5);
      chk("single_idle_T2", idle, 1);

      // ---------------- x0 filter ----------------
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
      chk("x0_lsu_ready", lsu_ready, 1);
      step();
      lsu_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("x0_wen_c%0d", i), wen, 0);
         chk($sformatf("x0_idle_c%0d", i), idle, 1);
         step();
      end
      chk("x0_wdata_hold", wdata, 32'hDEADBEEF);

      // ---------------- Priority and starvation ----------------
      wq_addr.delete(); wq_data.delete();
      exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h100;
      k = 2;
      guard = 0;
      while (k < 10 && guard < 60) begin
         lsu_valid = 1'b1;
         lsu_rd    = 5'(k);
         lsu_data  = 32'h200 + 32'(k);
         acc = lsu_ready;
         step();
         exu_valid = 1'b0;                      // taken on the first edge
         if (acc) k++;
         guard++;
      end
      lsu_valid = 1'b0;
      chk("starve_stream_done", k, 10);
      guard = 0;
      while (!idle && guard < 30) begin
         step();
         guard++;
      end
      chk("starve_drained", idle, 1);
      chk("starve_write_count", wq_addr.size(), 9);
      for (int i = 0; i < 9; i++) begin
         if (i < wq_addr.size()) begin
            chk($sformatf("starve_addr_%0d", i), wq_addr[i], st_addr[i]);
            chk($sformatf("starve_data_%0d", i), wq_data[i], st_data[i]);
         end
      end

      // ---------------- Backpressure ----------------
      wq_addr.delete(); wq_data.delete();
      ei = 0; li = 0; cyc = 0;
      while ((ei < 4 || li < 8) && cyc < 100) begin
         exu_valid = (ei < 4);
         exu_rd    = 5'(10 + ei);
         exu_data  = 32'hE000 + 32'(10 + ei);
         lsu_valid = (li < 8);
         lsu_rd    = 5'(20 + li);
         lsu_data  = 32'hF000 + 32'(20 + li);
         ea = exu_ready;
         la = lsu_ready;
         if (cyc < 6) chk($sformatf("bp_exu_ready_c%0d", cyc), ea, er_exp[cyc]);
         step();
         if (ea && exu_valid) ei++;
         if (la && lsu_valid) li++;
         cyc++;
      end
      exu_valid = 1'b0;
      lsu_valid = 1'b0;
      chk("bp_all_accepted", ei + li, 12);
      guard = 0;
      while (!idle && guard < 40) begin
         step();
         guard++;
      end
      chk("bp_drained", idle, 1);
      ne = 0; nl = 0;
      foreach (wq_addr[i]) begin
         if (wq_addr[i] < 5'd20) begin
            chk($sformatf("bp_exu_addr_%0d", ne), wq_addr[i], 10 + ne);
            chk($sformatf("bp_exu_data_%0d", ne), wq_data[i], 32'hE000 + 32'(10 + ne));
            ne++;
         end else begin
            chk($sformatf("bp_lsu_addr_%0d", nl), wq_addr[i], 20 + nl);
            chk($sformatf("bp_lsu_data_%0d", nl), wq_data[i], 32'hF000 + 32'(20 + nl));
            nl++;
         end
      end
      chk("bp_exu_count", ne, 4);
      chk("bp_lsu_count", nl, 8);

      // ---------------- Reset mid-operation ----------------
      for (int i = 0; i < 3; i++) begin
         exu_valid = 1'b1; exu_rd = 5'(12 + i); exu_data = 32'hBAD0_E000 + 32'(i);
         lsu_valid = 1'b1; lsu_rd = 5'(22 + i); lsu_data = 32'hBAD0_F000 + 32'(i);
         step();
      end
      chk("mid_exu_full", exu_ready, 0);
      chk("mid_busy", idle, 0);
      rst = 1'b0;
      exu_valid = 1'b0;
      lsu_valid = 1'b0;
      step();
      chk("mid_rst_wen", wen, 0);
      chk("mid_rst_idle", idle, 1);
      chk("mid_rst_exu_ready", exu_ready, 0);
      rst = 1'b1;
      wq_addr.delete(); wq_data.delete();
      for (int i = 0; i < 6; i++) begin
         step();
      end
      chk("mid_no_stale_writes", wq_addr.size(), 0);
      chk("mid_idle_after", idle, 1);

      // Fresh write after the mid-run reset goes through cleanly.
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h55;
      step();
      lsu_valid = 1'b0;
      step();
      chk("post_rst_wen", wen, 1);
      chk("post_rst_waddr", waddr, 3);
      chk("post_rst_wdata", wdata, 32'h55);
      step();
      chk("post_rst_wen_off", wen, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
